// File: rtl/note_pkg.sv
// rtl/note_pkg.sv - shared mode, play substate and event layout definitions
package note_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE   = 2'b00,
        MODE_RECORD = 2'b01,
        MODE_PLAY   = 2'b10
    } mode_t;

    typedef enum logic [1:0] {
        PLAY_FETCH  = 2'b00,
        PLAY_WAIT   = 2'b01,
        PLAY_FINISH = 2'b10
    } play_state_t;

    localparam int DEFAULT_CLK_DIV   = 50;
    localparam int DEFAULT_TIME_W    = 29;
    localparam int DEFAULT_KEY_IDX_W = 5;

    // Event word is {time, key_idx, press} with press in bit 0.
    localparam int EVT_PRESS_BIT = 0;
    localparam int EVT_KEY_LSB   = 1;

    function automatic int evt_time_lsb(input int key_idx_w);
        return EVT_KEY_LSB + key_idx_w;
    endfunction

    function automatic int evt_width(input int time_w, input int key_idx_w);
        return time_w + key_idx_w + 1;
    endfunction

endpackage

// File: rtl/note_event_ram.sv
// rtl/note_event_ram.sv - simple dual-port event buffer, one write port, registered read
module note_event_ram #(
    parameter int DATA_W = 35,
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/note_event_recorder.sv
// rtl/note_event_recorder.sv - timestamps key edges into a buffer and replays them with original timing
module note_event_recorder
    import note_pkg::*;
#(
    parameter int NUM_KEYS  = 29,
    parameter int KEY_IDX_W = 5,
    parameter int TIME_W    = 29,
    parameter int DEPTH     = 128,
    parameter int ADDR_W    = 7,
    parameter int CLK_DIV   = DEFAULT_CLK_DIV
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [NUM_KEYS-1:0] key_state,
    input  logic                record_start,
    input  logic                play_start,
    input  logic                stop,
    output logic [1:0]          mode,
    output logic [NUM_KEYS-1:0] play_keys,
    output logic [ADDR_W:0]     event_count,
    output logic                overflow,
    output logic                done,
    output logic [TIME_W-1:0]   elapsed_us
);

    localparam int EVT_W    = evt_width(TIME_W, KEY_IDX_W);
    localparam int TIME_LSB = evt_time_lsb(KEY_IDX_W);
    localparam int PRE_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0]     PRE_LAST   = PRE_W'(CLK_DIV - 1);
    localparam logic [ADDR_W:0]      FULL_COUNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [KEY_IDX_W-1:0] LAST_KEY   = KEY_IDX_W'(NUM_KEYS - 1);

    mode_t               mode_r;
    play_state_t         play_state;
    logic [PRE_W-1:0]    prescaler;
    logic [NUM_KEYS-1:0] logged;
    logic [ADDR_W:0]     rd_addr;

    logic [NUM_KEYS-1:0]  diff;
    logic                 has_diff;
    logic [KEY_IDX_W-1:0] diff_idx;
    logic                 diff_level;
    logic                 buf_full;
    logic                 wr_en;
    logic                 rd_en;
    logic [EVT_W-1:0]     wr_data;
    logic [EVT_W-1:0]     rd_data;
    logic [TIME_W-1:0]    rd_time;
    logic [KEY_IDX_W-1:0] rd_key;
    logic                 rd_press;
    logic [ADDR_W:0]      rd_addr_next;

    assign mode = mode_r;

    assign diff       = key_state ^ logged;
    assign has_diff   = |diff;
    assign diff_level = key_state[diff_idx];
    assign buf_full   = (event_count == FULL_COUNT);

    // Lowest changed key wins; the others wait for later cycles.
    always_comb begin
        diff_idx = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (diff[k]) begin
                diff_idx = KEY_IDX_W'(k);
            end
        end
    end

    assign wr_en   = (mode_r == MODE_RECORD) && !stop && has_diff && !buf_full;
    assign wr_data = {elapsed_us, diff_idx, diff_level};
    assign rd_en   = (mode_r == MODE_PLAY) && (play_state == PLAY_FETCH);

    assign rd_time      = rd_data[TIME_LSB +: TIME_W];
    assign rd_key       = rd_data[EVT_KEY_LSB +: KEY_IDX_W];
    assign rd_press     = rd_data[EVT_PRESS_BIT];
    assign rd_addr_next = rd_addr + (ADDR_W + 1)'(1);

    note_event_ram #(
        .DATA_W (EVT_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (event_count[ADDR_W-1:0]),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr[ADDR_W-1:0]),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mode_r      <= MODE_IDLE;
            play_state  <= PLAY_FETCH;
            prescaler   <= '0;
            elapsed_us  <= '0;
            logged      <= '0;
            event_count <= '0;
            overflow    <= 1'b0;
            done        <= 1'b0;
            play_keys   <= '0;
            rd_addr     <= '0;
        end else begin
            done <= 1'b0;

            // Timer runs only while a mode is active and holds its last value in IDLE.
            if (mode_r != MODE_IDLE) begin
                if (prescaler == PRE_LAST) begin
                    prescaler <= '0;
                    if (elapsed_us != '1) begin
                        elapsed_us <= elapsed_us + TIME_W'(1);
                    end
                end else begin
                    prescaler <= prescaler + PRE_W'(1);
                end
            end

            case (mode_r)
                MODE_IDLE: begin
                    if (!stop && record_start) begin
                        mode_r      <= MODE_RECORD;
                        prescaler   <= '0;
                        elapsed_us  <= '0;
                        event_count <= '0;
                        overflow    <= 1'b0;
                        logged      <= '0;
                    end else if (!stop && play_start) begin
                        prescaler  <= '0;
                        elapsed_us <= '0;
                        rd_addr    <= '0;
                        play_keys  <= '0;
                        play_state <= PLAY_FETCH;
                        if (event_count == '0) begin
                            done <= 1'b1;
                        end else begin
                            mode_r <= MODE_PLAY;
                        end
                    end
                end

                MODE_RECORD: begin
                    if (stop) begin
                        mode_r <= MODE_IDLE;
                    end else if (has_diff) begin
                        logged[diff_idx] <= diff_level;
                        if (buf_full) begin
                            overflow <= 1'b1;
                        end else begin
                            event_count <= event_count + (ADDR_W + 1)'(1);
                        end
                    end
                end

                MODE_PLAY: begin
                    if (stop) begin
                        mode_r     <= MODE_IDLE;
                        play_keys  <= '0;
                        play_state <= PLAY_FETCH;
                    end else begin
                        case (play_state)
                            PLAY_FETCH: play_state <= PLAY_WAIT;
                            PLAY_WAIT: begin
                                if (rd_time <= elapsed_us) begin
                                    if (rd_key <= LAST_KEY) begin
                                        play_keys[rd_key] <= rd_press;
                                    end
                                    rd_addr    <= rd_addr_next;
                                    play_state <= (rd_addr_next == event_count) ? PLAY_FINISH : PLAY_FETCH;
                                end
                            end
                            PLAY_FINISH: begin
                                done       <= 1'b1;
                                mode_r     <= MODE_IDLE;
                                play_keys  <= '0;
                                play_state <= PLAY_FETCH;
                            end
                            default: play_state <= PLAY_FETCH;
                        endcase
                    end
                end

                default: mode_r <= MODE_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_note_event_recorder.sv
// tb/tb_note_event_recorder.sv - scoreboard bench for the note event recorder
module tb_note_event_recorder;

    localparam int NK    = 29;
    localparam int KIW   = 5;
    localparam int TW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int CD    = 4;
    localparam int TMAX  = (1 << TW) - 1;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [NK-1:0] key_state = '0;
    logic          record_start = 1'b0;
    logic          play_start = 1'b0;
    logic          stop = 1'b0;
    logic [1:0]    mode;
    logic [NK-1:0] play_keys;
    logic [AW:0]   event_count;
    logic          overflow;
    logic          done;
    logic [TW-1:0] elapsed_us;

    note_event_recorder #(
        .NUM_KEYS  (NK),
        .KEY_IDX_W (KIW),
        .TIME_W    (TW),
        .DEPTH     (DEPTH),
        .ADDR_W    (AW),
        .CLK_DIV   (CD)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .key_state    (key_state),
        .record_start (record_start),
        .play_start   (play_start),
        .stop         (stop),
        .mode         (mode),
        .play_keys    (play_keys),
        .event_count  (event_count),
        .overflow     (overflow),
        .done         (done),
        .elapsed_us   (elapsed_us)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int t;
        int idx;
        bit press;
    } evt_t;

    typedef struct {
        bit            is_done;
        logic [NK-1:0] keys;
        int            t;
    } exp_t;

    evt_t          m_events[$];
    logic [NK-1:0] m_logged;
    bit            m_ovf;
    exp_t          exp_q[$];
    exp_t          mon_e;
    bit            mon_en = 1'b0;
    logic [NK-1:0] prev_keys = '0;
    int            sched_k[$];
    logic [NK-1:0] sched_mask[$];

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check(mode == 2'b00, {tag, "_mode"}, mode, 0);
        check(play_keys == '0, {tag, "_play_keys"}, play_keys, 0);
        check(event_count == '0, {tag, "_event_count"}, event_count, 0);
        check(overflow == 1'b0, {tag, "_overflow"}, overflow, 0);
        check(done == 1'b0, {tag, "_done"}, done, 0);
        check(elapsed_us == '0, {tag, "_elapsed"}, elapsed_us, 0);
    endtask

    // Spec rule: the lowest pending changed key is logged each cycle, dropped if full.
    task automatic model_step(input logic [NK-1:0] ks, input int t);
        logic [NK-1:0] pend;
        pend = ks ^ m_logged;
        for (int i = 0; i < NK; i++) begin
            if (pend[i]) begin
                if (m_events.size() < DEPTH) m_events.push_back('{t: t, idx: i, press: ks[i]});
                else m_ovf = 1'b1;
                m_logged[i] = ks[i];
                break;
            end
        end
    endtask

    task automatic do_record(input int n, input logic [NK-1:0] init_keys);
        int t;
        key_state = init_keys;
        record_start = 1'b1;
        @(posedge clk); #1;
        record_start = 1'b0;
        m_events.delete();
        m_logged = '0;
        m_ovf = 1'b0;
        for (int k = 1; k <= n; k++) begin
            while (sched_k.size() > 0 && sched_k[0] == k) begin
                key_state = key_state ^ sched_mask[0];
                void'(sched_k.pop_front());
                void'(sched_mask.pop_front());
            end
            @(posedge clk); #1;
            t = (k - 1) / CD;
            model_step(key_state, (t > TMAX) ? TMAX : t);
        end
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        sched_k.delete();
        sched_mask.delete();
    endtask

    task automatic wait_drain(input int budget);
        int c = 0;
        while (exp_q.size() > 0 && c < budget) begin
            @(posedge clk); #1;
            c++;
        end
        check(exp_q.size() == 0, "drain_timeout", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic do_play();
        logic [NK-1:0] keys = '0;
        foreach (m_events[j]) begin
            keys[m_events[j].idx] = m_events[j].press;
            exp_q.push_back('{is_done: 1'b0, keys: keys, t: m_events[j].t});
        end
        exp_q.push_back('{is_done: 1'b1, keys: '0, t: 0});
        mon_en = 1'b1;
        play_start = 1'b1;
        @(posedge clk); #1;
        play_start = 1'b0;
        wait_drain(3000);
        @(posedge clk); #1;
        mon_en = 1'b0;
    endtask

    task automatic gen_random(output int n);
        int k = 2;
        int toggles = 0;
        sched_k.delete();
        sched_mask.delete();
        while (toggles < 12) begin
            int nb;
            logic [NK-1:0] m;
            nb = int'($urandom_range(1, 3));
            m = '0;
            k += int'($urandom_range(8, 30));
            for (int b = 0; b < nb; b++) m[$urandom_range(0, NK - 1)] = 1'b1;
            sched_k.push_back(k);
            sched_mask.push_back(m);
            toggles += nb;
        end
        n = k + 20;
    endtask

    task automatic sched_add(input int k, input logic [NK-1:0] m);
        sched_k.push_back(k);
        sched_mask.push_back(m);
    endtask

    // Monitor: every done pulse or play_keys change consumes one expected item.
    always @(negedge clk) begin
        if (resetn && mon_en && (done || play_keys != prev_keys)) begin
            if (exp_q.size() == 0) begin
                check(1'b0, "unexpected_output", play_keys, 0);
            end else begin
                mon_e = exp_q.pop_front();
                if (done) begin
                    check(mon_e.is_done, "done_order", 1, mon_e.is_done);
                    check(play_keys == '0, "done_keys", play_keys, 0);
                    check(mode == 2'b00, "done_mode", mode, 0);
                end else begin
                    check(!mon_e.is_done && play_keys == mon_e.keys, "play_keys", play_keys, mon_e.keys);
                    check(int'(elapsed_us) >= mon_e.t && int'(elapsed_us) <= mon_e.t + 3,
                          "play_time", elapsed_us, mon_e.t);
                    check(mode == 2'b10, "play_mode", mode, 2);
                end
            end
        end
        prev_keys = play_keys;
    end

    initial begin
        int n;
        int c;
        bit seen;

        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        resetn = 1'b1;
        @(posedge clk); #1;
        check_all_zero("post_reset");

        // Play with an empty buffer: done on the very next cycle.
        exp_q.push_back('{is_done: 1'b1, keys: '0, t: 0});
        mon_en = 1'b1;
        play_start = 1'b1;
        @(posedge clk); #1;
        play_start = 1'b0;
        wait_drain(5);
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b0;

        // Single key press/release.
        sched_add(20, NK'(1) << 3);
        sched_add(60, NK'(1) << 3);
        do_record(80, '0);
        check(event_count == 2, "case1_count", event_count, 2);
        check(overflow == 1'b0, "case1_overflow", overflow, 0);
        check(elapsed_us == 8'((80 + 1) / CD), "case1_elapsed_frozen", elapsed_us, (80 + 1) / CD);
        do_play();

        // Stop during playback: keys clear, no done.
        play_start = 1'b1;
        @(posedge clk); #1;
        play_start = 1'b0;
        c = 0;
        while (elapsed_us != 8 && c < 200) begin
            @(negedge clk);
            c++;
        end
        check(c < 200, "stop_wait_timeout", c, 200);
        check(play_keys == NK'(1) << 3, "stop_pre_keys", play_keys, NK'(1) << 3);
        @(posedge clk); #1;
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        check(play_keys == '0, "stop_keys", play_keys, 0);
        check(mode == 2'b00, "stop_mode", mode, 0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check(!seen, "stop_no_done", seen, 0);
        @(posedge clk); #1;

        // Keys held before recording starts.
        do_record(10, (NK'(1) << 0) | (NK'(1) << 7));
        check(event_count == 2, "held_count", event_count, 2);
        do_play();

        // Key 9 toggles back before it is serviced: only key 2 is logged.
        sched_add(10, (NK'(1) << 2) | (NK'(1) << 9));
        sched_add(11, NK'(1) << 9);
        do_record(30, '0);
        check(event_count == 1, "toggle_back_count", event_count, 1);
        do_play();

        for (int r = 0; r < 4; r++) begin
            gen_random(n);
            do_record(n, '0);
            check(event_count == (AW + 1)'(m_events.size()), "rand_count", event_count, m_events.size());
            check(overflow == m_ovf, "rand_overflow", overflow, m_ovf);
            do_play();
        end

        // Overflow: 20 edges into a 16-entry buffer.
        for (int i = 0; i < 20; i++) sched_add(2 + 2 * i, NK'(1) << (i % 5));
        do_record(50, '0);
        check(event_count == DEPTH, "ovf_count", event_count, DEPTH);
        check(overflow == 1'b1, "ovf_flag", overflow, 1);
        do_record(5, '0);
        check(overflow == 1'b0, "ovf_cleared", overflow, 0);
        check(event_count == 0, "ovf_new_count", event_count, 0);

        // Timer saturation.
        sched_add(1050, NK'(1) << 5);
        do_record(1100, '0);
        check(elapsed_us == TW'(TMAX), "sat_elapsed", elapsed_us, TMAX);
        check(event_count == 1, "sat_count", event_count, 1);
        do_play();

        // Both starts together: record wins.
        key_state = '0;
        record_start = 1'b1;
        play_start = 1'b1;
        @(posedge clk); #1;
        record_start = 1'b0;
        play_start = 1'b0;
        check(mode == 2'b01, "both_starts_mode", mode, 1);
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        check(mode == 2'b00, "record_stop_mode", mode, 0);

        // Asynchronous reset mid-RECORD.
        key_state = NK'(1) << 4;
        record_start = 1'b1;
        @(posedge clk); #1;
        record_start = 1'b0;
        repeat (30) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check_all_zero("rst_record");
        @(posedge clk); #1;
        resetn = 1'b1;
        key_state = '0;

        // Asynchronous reset mid-PLAY.
        sched_add(20, NK'(1) << 3);
        sched_add(60, NK'(1) << 3);
        do_record(80, '0);
        play_start = 1'b1;
        @(posedge clk); #1;
        play_start = 1'b0;
        repeat (40) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check_all_zero("rst_play");
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/note_event_recorder.md
Name: note_event_recorder

Overview:
Parametrised successor to the single-purpose record handler. It timestamps key press and release edges on NUM_KEYS key lines into an internal event buffer (RECORD), then replays the buffer with the original timing onto a key-state output bus (PLAY). It sits between the keyboard/state-storage decode and the tone generator and screen handlers.

Parameters:
NUM_KEYS, 29, number of key lines.
KEY_IDX_W, 5, key index width; must satisfy 2**KEY_IDX_W >= NUM_KEYS.
TIME_W, 29, width of the microsecond timestamp.
DEPTH, 128, event buffer entries; must be a power of two.
ADDR_W, 7, equals log2(DEPTH).
CLK_DIV, 50, clk cycles per microsecond tick (50 MHz).

Ports:
clk  in  1  system clock; all logic on posedge.
resetn  in  1  asynchronous, active-low reset.
key_state  in  NUM_KEYS  live key levels; 1 = held; synchronous to clk.
record_start  in  1  single-cycle request to begin recording.
play_start  in  1  single-cycle request to begin playback.
stop  in  1  single-cycle request to abort or finish the current mode.
mode  out  2  current mode: 00 IDLE, 01 RECORD, 10 PLAY.
play_keys  out  NUM_KEYS  replayed key levels.
event_count  out  ADDR_W+1  number of valid events stored.
overflow  out  1  sticky flag: an event was dropped because the buffer was full.
done  out  1  one-cycle pulse when playback finishes naturally.
elapsed_us  out  TIME_W  timer value in the current mode.

Behaviour:
- Reset (asynchronous, active-low): all state returns to its reset value immediately.
  - mode = IDLE; play_keys, event_count, overflow, done, elapsed_us, prescaler and logged-state register all = 0.
  - RAM contents are not cleared; event_count = 0 makes the buffer empty.
- Requests and priority:
  - Priority when requests coincide: stop > record_start > play_start.
  - record_start and play_start are accepted only in IDLE and ignored otherwise.
  - stop in IDLE has no effect.
- Timebase:
  - The prescaler counts 0..CLK_DIV-1. elapsed_us increments on wrap.
  - elapsed_us saturates at all-ones and never wraps.
  - The prescaler and elapsed_us are both zeroed on the cycle a start is accepted.
- Event word: {time[TIME_W-1:0], key_idx[KEY_IDX_W-1:0], press}. Width is TIME_W+KEY_IDX_W+1 (35 bits at defaults).
- Entering RECORD (on accept):
  - event_count <= 0, overflow <= 0.
  - logged <= 0, so keys already held produce press events at t=0.
- In RECORD, each cycle:
  - diff = key_state ^ logged. If diff != 0, take i = lowest set bit.
  - Write {elapsed_us, i, key_state[i]} at address event_count, set logged[i] <= key_state[i], and event_count++.
  - Simultaneous changes are therefore serialised, one per cycle, in ascending index order; each carries the timestamp of its own write cycle.
  - A key that toggles back before it is serviced produces no event.
- Full buffer (event_count == DEPTH):
  - No write occurs and event_count holds.
  - overflow <= 1 when diff != 0, and logged[i] is still updated so the same edge is not retried.
  - Recording continues until stop.
- RECORD + stop: mode <= IDLE next cycle; event_count is frozen.
- PLAY:
  - Entry: rd_addr <= 0, play_keys <= 0.
  - If event_count == 0, done pulses the next cycle and mode returns to IDLE.
  - Otherwise two substates:
    - FETCH: issue the read at rd_addr (RAM has 1-cycle read latency).
    - WAIT: hold while data.time > elapsed_us. When data.time <= elapsed_us, set play_keys[key_idx] <= press and rd_addr++.
      - If the new rd_addr == event_count: the next cycle gives done = 1, mode = IDLE, play_keys <= 0.
      - Otherwise go to FETCH.
  - Maximum apply rate is one event per 2 cycles; a late event is applied immediately, so playback never skips events.
- PLAY + stop: play_keys <= 0, mode <= IDLE, no done pulse.
- key_state is ignored in PLAY and IDLE; play_keys = 0 outside PLAY.
- mode, done, play_keys and event_count are registered outputs.

Decomposition:
- Shared package (note_pkg) holds:
  - mode encodings MODE_IDLE/MODE_RECORD/MODE_PLAY;
  - the play substates;
  - the event field offset and width constants, derived from TIME_W and KEY_IDX_W;
  - the default CLK_DIV.
- One sub-module: note_event_ram. It is a simple dual-port RAM with DEPTH entries, one write port and one synchronous read port, the same style as the existing NoteStorage. The timebase stays inline.

Test Plan:
1. Sim with CLK_DIV=4. record_start; raise key 3 at cycle 20; drop it at cycle 60; stop -> event_count=2; events {4,3,1} and {14,3,0}; overflow=0.
2. Hold keys 0 and 7 before record_start -> events {0,0,1} then {0,7,1} on consecutive cycles; logged=0x81.
3. DEPTH=4; generate 6 edges during RECORD -> event_count=4, overflow=1. A following record_start clears overflow to 0.
4. Play case 1 -> play_keys[3] rises when elapsed_us reaches 4 and falls at 14. done pulses 1 cycle later; mode=00; play_keys=0.
5. Stop at elapsed_us=8 during case 4 playback -> play_keys=0 next cycle, no done. A subsequent play_start with event_count=0 after reset -> done the next cycle.
6. Assert resetn=0 mid-RECORD and mid-PLAY -> all outputs 0 asynchronously. record_start and play_start together in IDLE -> RECORD.
